// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: read ports, write port, reservation/flush
// controls and the observability outputs.
interface regfile_scoreboard_if #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int MIRROR_N = 8
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic [NRD*AW-1:0]        RA;
    logic [NRD-1:0]           RE;
    logic [NRD*XLEN-1:0]      RD;
    logic [NRD-1:0]           RBUSY;
    logic [AW-1:0]            WA;
    logic [XLEN-1:0]          WD;
    logic                     WE;
    logic [AW-1:0]            RSV_A;
    logic                     RSV_EN;
    logic                     FLUSH;
    logic [CW-1:0]            PEND_CNT;
    logic [MIRROR_N*XLEN-1:0] MIRROR;

    modport master (
        output RA, RE, WA, WD, WE, RSV_A, RSV_EN, FLUSH,
        input  RD, RBUSY, PEND_CNT, MIRROR
    );

    modport slave (
        input  RA, RE, WA, WD, WE, RSV_A, RSV_EN, FLUSH,
        output RD, RBUSY, PEND_CNT, MIRROR
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with registered reads, write bypass, optional
// hardwired-zero register and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int MIRROR_N = 8
) (
    input  logic                 RST,
    input  logic                 CLK_DC,
    regfile_scoreboard_if.slave  bus
);
    localparam int          AW = $clog2(NREGS);
    localparam int          CW = $clog2(NREGS + 1);
    localparam int unsigned NR = NREGS;
    localparam int unsigned NP = NRD;
    localparam int unsigned NM = MIRROR_N;

    if (NREGS < 2) begin : g_chk_nregs
        $error("NREGS must be at least 2");
    end
    if (NRD < 1 || NRD > 4) begin : g_chk_nrd
        $error("NRD must be in 1..4");
    end
    if (MIRROR_N < 1 || MIRROR_N > NREGS) begin : g_chk_mirror
        $error("MIRROR_N must be in 1..NREGS");
    end

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    pend_q;
    logic [NREGS-1:0]    pend_d;
    logic [NRD*XLEN-1:0] rd_q;
    logic [NRD*XLEN-1:0] rd_d;
    logic [NRD-1:0]      rbusy_q;
    logic [NRD-1:0]      rbusy_d;
    logic [CW-1:0]       pend_cnt;
    logic [MIRROR_N*XLEN-1:0] mirror;
    logic                wr_eff;
    logic                rsv_eff;

    // Address names a real, writable register (in range and not the zero reg).
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (32'(a) < NR) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_eff  = bus.WE && addr_ok(bus.WA);
    assign rsv_eff = bus.RSV_EN && addr_ok(bus.RSV_A);

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            for (int unsigned r = 0; r < NR; r++) begin
                regs[r] <= '0;
            end
        end else if (wr_eff) begin
            regs[bus.WA] <= bus.WD;
        end
    end

    // Reads see the same-cycle write (bypass) but never a same-cycle reserve.
    always_comb begin
        logic [AW-1:0] ra;
        rd_d    = rd_q;
        rbusy_d = rbusy_q;
        ra      = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            ra = bus.RA[i*AW +: AW];
            if (bus.RE[i]) begin
                if (!addr_ok(ra)) begin
                    rd_d[i*XLEN +: XLEN] = '0;
                    rbusy_d[i]           = 1'b0;
                end else if (wr_eff && (bus.WA == ra)) begin
                    rd_d[i*XLEN +: XLEN] = bus.WD;
                    rbusy_d[i]           = 1'b0;
                end else begin
                    rd_d[i*XLEN +: XLEN] = regs[ra];
                    rbusy_d[i]           = pend_q[ra];
                end
            end
        end
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            rd_q    <= '0;
            rbusy_q <= '0;
        end else begin
            rd_q    <= rd_d;
            rbusy_q <= rbusy_d;
        end
    end

    // Ordering: write clears, then reserve sets (so reserve wins), then flush wipes.
    always_comb begin
        pend_d = pend_q;
        if (wr_eff) begin
            pend_d[bus.WA] = 1'b0;
        end
        if (rsv_eff) begin
            pend_d[bus.RSV_A] = 1'b1;
        end
        if (bus.FLUSH) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge CLK_DC or negedge RST) begin
        if (!RST) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int unsigned r = 0; r < NR; r++) begin
            pend_cnt = pend_cnt + CW'(pend_q[r]);
        end
    end

    always_comb begin
        mirror = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            mirror[(NM-1-k)*XLEN +: XLEN] = regs[NR-NM+k];
        end
    end

    assign bus.RD       = rd_q;
    assign bus.RBUSY    = rbusy_q;
    assign bus.PEND_CNT = pend_cnt;
    assign bus.MIRROR   = mirror;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard (32x32, 2 read ports, zero reg).
module tb_regfile_scoreboard;
    localparam int XLEN     = 32;
    localparam int NREGS    = 32;
    localparam int NRD      = 2;
    localparam int MIRROR_N = 8;

    logic CLK_DC = 1'b0;
    logic RST    = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    regfile_scoreboard_if #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .MIRROR_N(MIRROR_N)
    ) ifc ();

    regfile_scoreboard #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1), .MIRROR_N(MIRROR_N)
    ) dut (
        .RST   (RST),
        .CLK_DC(CLK_DC),
        .bus   (ifc.slave)
    );

    always #5 CLK_DC = ~CLK_DC;

    function automatic logic [XLEN-1:0] rd(input int i);
        return ifc.RD[i*XLEN +: XLEN];
    endfunction

    task automatic tick();
        @(posedge CLK_DC);
        #1;
    endtask

    task automatic idle();
        ifc.RA     = '0;
        ifc.RE     = '0;
        ifc.WA     = '0;
        ifc.WD     = '0;
        ifc.WE     = 1'b0;
        ifc.RSV_A  = '0;
        ifc.RSV_EN = 1'b0;
        ifc.FLUSH  = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        RST = 1'b0;
        #12;
        checks++;
        if (ifc.RD !== '0) begin
            failures++; $display("FAIL reset_rd: got %h expected 0", ifc.RD);
        end
        @(negedge CLK_DC);
        RST    = 1'b1;
        ifc.RE = 2'b11;
        ifc.RA = {5'd5, 5'd0};
        tick();
        checks++;
        if (ifc.RD !== '0) begin
            failures++; $display("FAIL reset_read: got %h expected 0", ifc.RD);
        end
        checks++;
        if (ifc.RBUSY !== 2'b00) begin
            failures++; $display("FAIL reset_rbusy: got %b expected 00", ifc.RBUSY);
        end
        checks++;
        if (ifc.PEND_CNT !== 6'd0) begin
            failures++; $display("FAIL reset_pend: got %0d expected 0", ifc.PEND_CNT);
        end
    endtask

    task automatic test_bypass();
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd5; ifc.WD = 32'hDEADBEEF;
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd5};
        tick();
        checks++;
        if (rd(0) !== 32'hDEADBEEF) begin
            failures++; $display("FAIL bypass_rd0: got %h expected deadbeef", rd(0));
        end
        checks++;
        if (rd(1) !== 32'h0) begin
            failures++; $display("FAIL bypass_rd1_hold: got %h expected 0", rd(1));
        end
        idle();
        ifc.RE = 2'b11; ifc.RA = {5'd5, 5'd5};
        tick();
        checks++;
        if (ifc.RD !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            failures++; $display("FAIL dual_read_5: got %h expected deadbeefdeadbeef", ifc.RD);
        end
        idle();
        ifc.RE = 2'b00; ifc.RA = {5'd1, 5'd1};
        ifc.WE = 1'b1; ifc.WA = 5'd1; ifc.WD = 32'h11;
        tick();
        checks++;
        if (ifc.RD !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            failures++; $display("FAIL re0_hold: got %h expected deadbeefdeadbeef", ifc.RD);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd0; ifc.WD = 32'h1234;
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd0};
        tick();
        checks++;
        if (rd(0) !== 32'h0) begin
            failures++; $display("FAIL zero_bypass: got %h expected 0", rd(0));
        end
        idle();
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd0;
        ifc.RE = 2'b10; ifc.RA = {5'd0, 5'd0};
        tick();
        checks++;
        if (rd(1) !== 32'h0) begin
            failures++; $display("FAIL zero_read: got %h expected 0", rd(1));
        end
        checks++;
        if (ifc.PEND_CNT !== 6'd0) begin
            failures++; $display("FAIL zero_reserve: got %0d expected 0", ifc.PEND_CNT);
        end
    endtask

    task automatic test_reserve();
        idle();
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd7;
        tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd1) begin
            failures++; $display("FAIL rsv7_pend: got %0d expected 1", ifc.PEND_CNT);
        end
        idle();
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd7};
        tick();
        checks++;
        if (ifc.RBUSY[0] !== 1'b1) begin
            failures++; $display("FAIL rsv7_busy: got %b expected 1", ifc.RBUSY[0]);
        end
        idle();
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd8;
        ifc.RE = 2'b10; ifc.RA = {5'd8, 5'd0};
        tick();
        checks++;
        if (ifc.RBUSY !== 2'b01) begin
            failures++; $display("FAIL rsv_not_visible: got %b expected 01", ifc.RBUSY);
        end
        checks++;
        if (ifc.PEND_CNT !== 6'd2) begin
            failures++; $display("FAIL rsv8_pend: got %0d expected 2", ifc.PEND_CNT);
        end
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd8; ifc.WD = 32'h88;
        ifc.RE = 2'b10; ifc.RA = {5'd8, 5'd0};
        tick();
        checks++;
        if (ifc.RBUSY[1] !== 1'b0 || rd(1) !== 32'h88) begin
            failures++; $display("FAIL wr8_clears: got busy=%b rd=%h expected busy=0 rd=88", ifc.RBUSY[1], rd(1));
        end
        checks++;
        if (ifc.PEND_CNT !== 6'd1) begin
            failures++; $display("FAIL wr8_pend: got %0d expected 1", ifc.PEND_CNT);
        end
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd7; ifc.WD = 32'h77;
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd7;
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd7};
        tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd1) begin
            failures++; $display("FAIL wr_rsv_same: got %0d expected 1", ifc.PEND_CNT);
        end
        checks++;
        if (ifc.RBUSY[0] !== 1'b0 || rd(0) !== 32'h77) begin
            failures++; $display("FAIL wr_rsv_read: got busy=%b rd=%h expected busy=0 rd=77", ifc.RBUSY[0], rd(0));
        end
        idle();
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd7};
        tick();
        checks++;
        if (ifc.RBUSY[0] !== 1'b1) begin
            failures++; $display("FAIL rsv_wins_busy: got %b expected 1", ifc.RBUSY[0]);
        end
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd7; ifc.WD = 32'h99;
        tick();
        idle();
        ifc.RE = 2'b01; ifc.RA = {5'd0, 5'd7};
        tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd0) begin
            failures++; $display("FAIL wr7_pend: got %0d expected 0", ifc.PEND_CNT);
        end
        checks++;
        if (ifc.RBUSY[0] !== 1'b0 || rd(0) !== 32'h99) begin
            failures++; $display("FAIL wr7_read: got busy=%b rd=%h expected busy=0 rd=99", ifc.RBUSY[0], rd(0));
        end
    endtask

    task automatic test_flush_mirror();
        idle();
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd3;  tick();
        ifc.RSV_A = 5'd4;  tick();
        ifc.RSV_A = 5'd9;  tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd3) begin
            failures++; $display("FAIL rsv3_pend: got %0d expected 3", ifc.PEND_CNT);
        end
        ifc.FLUSH = 1'b1; ifc.RSV_A = 5'd10;
        ifc.WE = 1'b1; ifc.WA = 5'd12; ifc.WD = 32'h55;
        tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd0) begin
            failures++; $display("FAIL flush_pend: got %0d expected 0", ifc.PEND_CNT);
        end
        idle();
        ifc.RE = 2'b11; ifc.RA = {5'd10, 5'd12};
        tick();
        checks++;
        if (ifc.RD !== {32'h0, 32'h55} || ifc.RBUSY !== 2'b00) begin
            failures++; $display("FAIL flush_write: got rd=%h busy=%b expected rd=0000000000000055 busy=00", ifc.RD, ifc.RBUSY);
        end
        idle();
        ifc.WE = 1'b1; ifc.WA = 5'd31; ifc.WD = 32'hA5;
        tick();
        checks++;
        if (ifc.MIRROR[XLEN-1:0] !== 32'hA5) begin
            failures++; $display("FAIL mirror_low: got %h expected a5", ifc.MIRROR[XLEN-1:0]);
        end
        ifc.WA = 5'd24; ifc.WD = 32'h24;
        tick();
        checks++;
        if (ifc.MIRROR[MIRROR_N*XLEN-1 -: XLEN] !== 32'h24) begin
            failures++; $display("FAIL mirror_high: got %h expected 24", ifc.MIRROR[MIRROR_N*XLEN-1 -: XLEN]);
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle();
        ifc.RSV_EN = 1'b1; ifc.RSV_A = 5'd2; tick();
        ifc.RSV_A = 5'd6; tick();
        idle();
        ifc.RE = 2'b11; ifc.RA = {5'd6, 5'd5};
        tick();
        checks++;
        if (ifc.PEND_CNT !== 6'd2 || rd(0) !== 32'hDEADBEEF || ifc.RBUSY !== 2'b10) begin
            failures++; $display("FAIL pre_reset: got pend=%0d rd0=%h busy=%b expected pend=2 rd0=deadbeef busy=10", ifc.PEND_CNT, rd(0), ifc.RBUSY);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++;
        if (ifc.RD !== '0 || ifc.RBUSY !== 2'b00 || ifc.PEND_CNT !== 6'd0 || ifc.MIRROR !== '0) begin
            failures++; $display("FAIL async_reset: got rd=%h busy=%b pend=%0d expected all 0", ifc.RD, ifc.RBUSY, ifc.PEND_CNT);
        end
        @(negedge CLK_DC);
        RST = 1'b1;
        ifc.RE = 2'b11; ifc.RA = {5'd31, 5'd5};
        tick();
        checks++;
        if (ifc.RD !== '0) begin
            failures++; $display("FAIL post_reset_read: got %h expected 0", ifc.RD);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_reserve();
        test_flush_mirror();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
